// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared constants and state type for the program loader
package program_loader_pkg;

    localparam logic [7:0] LOADER_MAGIC = 8'hA5;
    localparam int         LEN_WIDTH    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // States that sit inside a frame and are therefore guarded by the idle timeout.
    function automatic logic in_frame(state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, instruction memory byte write port out
interface program_loader_if;

    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [7:0]  wr_data_o;

    modport master (
        output byte_i, byte_valid_i,
        input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  byte_i, byte_valid_i,
        output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o
    );

endinterface

// File: rtl/program_loader_timeout.sv
// rtl/program_loader_timeout.sv - idle-cycle counter that expires after LIMIT quiet cycles
module loader_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int             CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q, count_d;

    // A byte arriving on the expiring cycle clears instead of expiring.
    assign expire_o = enable_i && !clear_i && (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (!enable_i || clear_i || expire_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader writing the instruction store, holds core in reset
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEM_BYTES      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    program_loader_if.slave   bus,
    output logic              cpu_reset_o,
    output logic              done_o,
    output logic              error_o
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MEM_BYTES);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]           sum_q, sum_d;
    logic                 wr_en_q, wr_en_d;
    logic [LEN_WIDTH-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 accept;
    logic                 expire;
    logic [LEN_WIDTH-1:0] len_full;
    logic [LEN_WIDTH-1:0] idx_next;

    assign bus.byte_ready_o = !rst_i;
    assign accept           = bus.byte_valid_i && !rst_i;
    assign len_full         = {bus.byte_i, len_q[7:0]};
    assign idx_next         = idx_q + LEN_WIDTH'(1);

    loader_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (in_frame(state_q)),
        .clear_i  (accept),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (expire) begin
            state_d = ST_ERROR;
        end else if (accept) begin
            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.byte_i == LOADER_MAGIC) begin
                        state_d = ST_LEN_LO;
                        idx_d   = '0;
                        sum_d   = '0;
                    end
                end
                ST_LEN_LO: begin
                    len_d   = {8'h00, bus.byte_i};
                    state_d = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    len_d = len_full;
                    if (len_full == '0) begin
                        state_d = ST_CHECK;
                    end else if (len_full > MAX_LEN) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    wr_en_d   = 1'b1;
                    wr_idx_d  = idx_q;
                    wr_data_d = bus.byte_i;
                    idx_d     = idx_next;
                    sum_d     = sum_q + bus.byte_i;
                    if (idx_next == len_q) begin
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state_d = (bus.byte_i == sum_q) ? ST_DONE : ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_addr_o = {16'h0000, wr_idx_q};
    assign bus.wr_data_o = wr_data_q;
    assign cpu_reset_o   = (state_q != ST_DONE);
    assign done_o        = (state_q == ST_DONE);
    assign error_o       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_reset, done, error;

    program_loader_if bus();

    program_loader #(.MEM_BYTES(32), .TIMEOUT_CYCLES(1024)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .cpu_reset_o (cpu_reset),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t got[$];

    always @(negedge clk) begin
        if (bus.wr_en_o === 1'b1) got.push_back('{int'(bus.wr_addr_o), int'(bus.wr_data_o), cyc});
    end

    typedef struct {
        logic [7:0] b[0:39];
        int         n;
        int         exp_nwr;
        logic       exp_done;
        logic       exp_err;
    } vec_t;
    vec_t vt[8];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(logic [7:0] b);
        bus.byte_i       = b;
        bus.byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic send_q(input logic [7:0] s[$]);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.byte_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic load_hex(int t, logic [127:0] h, int nb);
        for (int i = 0; i < nb; i++) begin
            vt[t].b[vt[t].n] = h[8*(nb-1-i) +: 8];
            vt[t].n++;
        end
    endtask

    // Reference parser over the whole byte stream: st 0 = idle/in-frame, 1 = done, 2 = error.
    task automatic model(input logic [7:0] s[$], output wr_t ew[$], output int st);
        int         i, n, len;
        logic [7:0] sum;
        ew.delete();
        st = 0;
        i  = 0;
        n  = s.size();
        while (i < n) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            st = 0;
            i++;
            if (i + 2 > n) break;
            len = int'({s[i+1], s[i]});
            i += 2;
            if (len > 32) begin
                st = 2;
                continue;
            end
            sum = 8'h00;
            for (int k = 0; k < len && i < n; k++) begin
                ew.push_back('{k, int'(s[i]), 0});
                sum = sum + s[i];
                i++;
            end
            if (i >= n || ew.size() < len) break;
            st = (s[i] == sum) ? 1 : 2;
            i++;
        end
    endtask

    task automatic compare_model(string name, input logic [7:0] s[$]);
        wr_t ew[$];
        int  st;
        model(s, ew, st);
        check({name, " nwr"}, got.size(), ew.size());
        for (int k = 0; k < ew.size() && k < got.size(); k++) begin
            check({name, " addr"}, got[k].addr, ew[k].addr);
            check({name, " data"}, got[k].data, ew[k].data);
        end
        check({name, " done"}, done, st == 1);
        check({name, " error"}, error, st == 2);
        check({name, " cpu_reset"}, cpu_reset, st != 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] s[$];
        int         len;
        logic [7:0] sum;

        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;

        for (int t = 0; t < 8; t++) vt[t].n = 0;
        load_hex(0, 128'hA5_04_00_13_05_10_00_28, 8);
        vt[0].exp_nwr = 4;  vt[0].exp_done = 1'b1; vt[0].exp_err = 1'b0;
        load_hex(1, 128'hA5_02_00_FF_02_00, 6);
        vt[1].exp_nwr = 2;  vt[1].exp_done = 1'b0; vt[1].exp_err = 1'b1;
        load_hex(2, 128'hA5_21_00, 3);
        vt[2].exp_nwr = 0;  vt[2].exp_done = 1'b0; vt[2].exp_err = 1'b1;
        load_hex(3, 128'hA5_00_00_00, 4);
        vt[3].exp_nwr = 0;  vt[3].exp_done = 1'b1; vt[3].exp_err = 1'b0;
        load_hex(4, 128'h12_34_A5_01_00_7F_7F, 7);
        vt[4].exp_nwr = 1;  vt[4].exp_done = 1'b1; vt[4].exp_err = 1'b0;
        load_hex(5, 128'hA5_20_00, 3);
        for (int k = 0; k < 32; k++) load_hex(5, 128'(k), 1);
        load_hex(5, 128'hF0_00_00, 3);
        vt[5].exp_nwr = 32; vt[5].exp_done = 1'b1; vt[5].exp_err = 1'b0;
        load_hex(6, 128'hA5_01_00_FF_00, 5);
        vt[6].exp_nwr = 1;  vt[6].exp_done = 1'b0; vt[6].exp_err = 1'b1;
        load_hex(7, 128'hA5_00_01, 3);
        vt[7].exp_nwr = 0;  vt[7].exp_done = 1'b0; vt[7].exp_err = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        check("reset ready", bus.byte_ready_o, 1'b0);
        check("reset wr_en", bus.wr_en_o, 1'b0);
        check("reset wr_addr", bus.wr_addr_o, 32'h0);
        check("reset wr_data", bus.wr_data_o, 8'h00);
        check("reset cpu_reset", cpu_reset, 1'b1);
        check("reset done", done, 1'b0);
        check("reset error", error, 1'b0);

        // Table-driven frames
        for (int t = 0; t < 8; t++) begin
            s.delete();
            for (int i = 0; i < vt[t].n; i++) s.push_back(vt[t].b[i]);
            do_reset();
            send_q(s);
            settle();
            check($sformatf("vec%0d nwr", t), got.size(), vt[t].exp_nwr);
            check($sformatf("vec%0d done", t), done, vt[t].exp_done);
            check($sformatf("vec%0d error", t), error, vt[t].exp_err);
            check($sformatf("vec%0d cpu_reset", t), cpu_reset, !vt[t].exp_done);
            compare_model($sformatf("vec%0d model", t), s);
            if (t == 0 && got.size() == 4) begin
                for (int k = 1; k < 4; k++) check("b2b strobe cycle", got[k].cyc, got[0].cyc + k);
            end
            if (t == 5 && got.size() == 32) check("len32 last addr", got[31].addr, 31);
        end

        // Write strobe lasts exactly the cycle after acceptance
        do_reset();
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h5A);
        check("strobe wr_en", bus.wr_en_o, 1'b1);
        check("strobe addr", bus.wr_addr_o, 32'h0);
        check("strobe data", bus.wr_data_o, 8'h5A);
        @(posedge clk);
        #1;
        check("strobe drop", bus.wr_en_o, 1'b0);
        send(8'h5A);
        check("strobe frame done", done, 1'b1);
        bus.byte_i = 8'hA5;
        repeat (5) @(posedge clk);
        #1;
        check("valid low ignored", done, 1'b1);

        // Timeout boundary: 1023 idle cycles survive, the 1024th aborts
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00); send(8'h11);
        repeat (1023) @(posedge clk);
        #1;
        check("timeout not yet", error, 1'b0);
        @(posedge clk);
        #1;
        check("timeout error", error, 1'b1);
        check("timeout cpu_reset", cpu_reset, 1'b1);
        check("timeout kept write", got.size(), 1);
        if (got.size() == 1) check("timeout write data", got[0].data, 8'h11);
        got.delete();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h22); send(8'h22);
        settle();
        check("after timeout done", done, 1'b1);
        check("after timeout nwr", got.size(), 1);

        // A byte on the expiring cycle wins over the timeout
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00); send(8'h11);
        repeat (1023) @(posedge clk);
        #1;
        send(8'h22);
        check("late byte no error", error, 1'b0);
        send(8'h33);
        check("late byte done", done, 1'b1);

        // Reset in the middle of DATA, then a fresh frame
        do_reset();
        send(8'hA5); send(8'h04); send(8'h00); send(8'h01); send(8'h02);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst ready", bus.byte_ready_o, 1'b0);
        check("midrst wr_en", bus.wr_en_o, 1'b0);
        check("midrst addr", bus.wr_addr_o, 32'h0);
        check("midrst data", bus.wr_data_o, 8'h00);
        check("midrst cpu_reset", cpu_reset, 1'b1);
        check("midrst done", done, 1'b0);
        check("midrst error", error, 1'b0);
        rst = 1'b0;
        got.delete();
        s = {8'hA5, 8'h04, 8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h2E};
        send_q(s);
        settle();
        compare_model("midrst reload", s);

        // Randomized streams against the reference parser
        for (int it = 0; it < 40; it++) begin
            s.delete();
            repeat ($urandom_range(0, 2)) s.push_back(8'($urandom_range(0, 255)));
            len = $urandom_range(0, 36);
            s.push_back(8'hA5);
            s.push_back(8'(len));
            s.push_back(8'h00);
            sum = 8'h00;
            for (int k = 0; k < len; k++) begin
                s.push_back(8'($urandom_range(0, 255)));
                sum = sum + s[s.size()-1];
            end
            s.push_back(($urandom_range(0, 3) == 0) ? sum + 8'h01 : sum);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) void'(s.pop_back());
            do_reset();
            send_q(s);
            settle();
            compare_model($sformatf("rand%0d", it), s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory: receives a framed program image as a byte stream and writes it byte-by-byte into the byte-wide instruction store.
- Each byte is written at byte address N in little-endian word order, the same order instruction fetch reads it back.
- Holds the core in reset while loading; releases it only after a frame passes its length and checksum checks.
- Sits between the host byte source (UART RX or testbench) and the instruction memory write port.

Parameters:
- MEM_BYTES, 32: instruction store size in bytes; largest legal payload length.
- TIMEOUT_CYCLES, 1024: maximum idle cycles between bytes inside a frame before the frame is aborted.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- byte_i  input  8  incoming stream byte
- byte_valid_i  input  1  byte_i valid this cycle
- byte_ready_o  output  1  loader accepts byte this cycle; a byte transfers when valid and ready are both high
- wr_en_o  output  1  instruction memory byte write strobe
- wr_addr_o  output  32  byte address (zero-extended 16-bit index)
- wr_data_o  output  8  byte to write
- cpu_reset_o  output  1  holds the core in reset
- done_o  output  1  last frame loaded and checksum passed
- error_o  output  1  last frame aborted

Behaviour:
- Frame format: 0xA5 magic, LEN_LO, LEN_HI (16-bit byte count, little-endian), LEN payload bytes, CHK.
  - CHK = 8-bit modulo-256 sum of the payload bytes.
- States and transitions:
  - IDLE: accepts and discards any byte except 0xA5; 0xA5 -> LEN_LO.
  - LEN_LO: accepted byte -> LEN_HI.
  - LEN_HI: accepted byte -> DATA, or -> CHECK if LEN == 0, or -> ERROR if LEN > MEM_BYTES.
  - DATA: each accepted byte is written; after the LEN-th byte -> CHECK.
  - CHECK: accepted byte equal to the running sum -> DONE; otherwise -> ERROR.
  - DONE, ERROR: behave as IDLE for incoming bytes; 0xA5 starts a new frame -> LEN_LO.
- Reset (rst_i high at a clock edge, including mid-frame): state IDLE, byte index 0, sum 0, timeout counter 0.
  - Outputs: wr_en_o 0, wr_addr_o 0, wr_data_o 0, done_o 0, error_o 0, cpu_reset_o 1.
  - Bytes already written are not cleared.
- byte_ready_o = !rst_i (combinational); the loader never back-pressures. A byte with valid low is ignored.
- Write timing: a byte accepted in DATA at edge k produces wr_en_o = 1, wr_addr_o = index, wr_data_o = byte for exactly the cycle after edge k (registered). The index increments after each write.
  - Back-to-back bytes produce back-to-back strobes.
- Index and sum are cleared on every transition into LEN_LO.
- cpu_reset_o = 0 only in DONE; 1 in every other state, including while a new frame is loading after DONE.
- done_o = 1 only in DONE. error_o = 1 only in ERROR. Both are registered and change on the same edge as the state.
- Timeout: applies in LEN_LO, LEN_HI, DATA and CHECK only.
  - The counter increments on every cycle without an accepted byte and clears on acceptance.
  - Reaching TIMEOUT_CYCLES -> ERROR.
  - A byte accepted on the same cycle the counter would expire wins: it is processed and no timeout occurs.
- LEN == MEM_BYTES is legal; the final address is MEM_BYTES-1.
- Sum arithmetic wraps mod 256. The length compare is an unsigned 16-bit compare.

Decomposition:
- Shared package (riscv_pkg): state encoding localparams, LOADER_MAGIC = 8'hA5, LEN_WIDTH = 16.
- No sub-module required. Optionally factor the timeout counter as loader_timeout (count, clear, expire), instantiated once.

Test Plan:
- Load A5 04 00 13 05 10 00 28 -> writes 13,05,10,00 at addresses 0..3 on consecutive cycles; DONE; cpu_reset_o 0; done_o 1.
- Load A5 02 00 FF 02 00 (bad CHK, correct value 01) -> two writes occur, then ERROR; error_o 1; cpu_reset_o stays 1.
- Load A5 21 00 (LEN 33 > 32) -> no writes; ERROR after LEN_HI.
- Send LEN 32 with bytes 00..1F and CHK F0 -> last write at address 31; DONE. Then send 00 00 -> state remains DONE.
- Send A5 02 00 11, then idle 1024 cycles -> ERROR; the single write at address 0 is retained. Then a valid frame -> DONE.
- Assert rst_i mid-DATA after 2 of 4 bytes, then a fresh valid frame -> all outputs at reset values; the new frame loads from address 0; DONE.
